// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide: radix-2 shift-add multiply, restoring divide, one bit per cycle.
// Latency 33 cycles from accepted start to done (1 for divide-by-zero/overflow); busy stalls the pipe until done.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [4:0]      ALUsel,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [5:0]      LAST    = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [2:0]        op;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic              neg_q;
    logic              neg_r;
    logic [5:0]        cnt;

    // Operand decode for the request presented in IDLE
    logic            is_m, is_div, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, spec_val;

    assign is_m     = (ALUsel[4:3] == 2'b10);
    assign is_div   = ALUsel[2];
    assign sgn_a    = is_div ? ~ALUsel[0] : (ALUsel[1:0] == 2'b01 || ALUsel[1:0] == 2'b10);
    assign sgn_b    = is_div ? ~ALUsel[0] : (ALUsel[1:0] == 2'b01);
    assign neg_a    = sgn_a & a[XLEN-1];
    assign neg_b    = sgn_b & b[XLEN-1];
    assign mag_a    = neg_a ? -a : a;
    assign mag_b    = neg_b ? -b : b;
    assign div_zero = is_div && (b == '0);
    assign div_ovf  = is_div && !ALUsel[0] && (a == INT_MIN) && (b == '1);
    assign spec_val = div_zero ? (ALUsel[1] ? a : '1) : (ALUsel[1] ? '0 : a);

    // One iteration step; acc holds {partial product hi, multiplier} or {remainder, dividend/quotient}
    logic [XLEN:0]     sum, diff;
    logic [2*XLEN-1:0] acc_next, prod;
    logic [XLEN-1:0]   quo, rmd, fin;

    always_comb begin
        sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        if (op[2])
            acc_next = diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                  : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_next = {sum, acc[XLEN-1:1]};
        prod = neg_q ? -acc_next : acc_next;
        quo  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rmd  = neg_r ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        if (op[2])
            fin = op[1] ? rmd : quo;
        else
            fin = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op     <= '0;
            opnd   <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && is_m) begin
                            op    <= ALUsel[2:0];
                            opnd  <= is_div ? mag_b : mag_a;
                            acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                            neg_q <= neg_a ^ neg_b;
                            neg_r <= neg_a;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            if (div_zero || div_ovf) begin
                                state  <= DONE;
                                result <= spec_val;
                                done   <= 1'b1;
                            end else begin
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        acc <= acc_next;
                        cnt <= cnt + 6'd1;
                        // Sign fixup rides on the last iteration so result is valid with done
                        if (cnt == LAST) begin
                            state  <= DONE;
                            result <= fin;
                            done   <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus literal RV32M cases, kill/reset/ignore scenarios and random ops.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, kill;
    logic [4:0]  ALUsel;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .ALUsel(ALUsel),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [4:0] sel, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, uy, p;
        logic [63:0]        up;
        logic signed [31:0] xs, ys, q;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        uy = {32'b0, y};
        xs = x;
        ys = y;
        case (sel[2:0])
            3'd0: return x * y;
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
                q = xs / ys; return q;
            end
            3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                q = xs % ys; return q;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_special(input logic [4:0] sel, input logic [31:0] x, input logic [31:0] y);
        return sel[2] && (y == 0 || (!sel[0] && x == 32'h80000000 && y == 32'hFFFFFFFF));
    endfunction

    // Reference: cycles left until idle (1 = done cycle), visible result, pending answer
    int          m_left = 0;
    logic [31:0] m_res  = 0;
    logic [31:0] m_pend = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_res  = 0;
        end else if (kill) begin
            m_left = 0;
        end else if (m_left == 0) begin
            if (start && ALUsel[4]) begin
                m_pend = ref_op(ALUsel, a, b);
                m_left = is_special(ALUsel, a, b) ? 1 : 33;
                if (m_left == 1) m_res = m_pend;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 1) m_res = m_pend;
        end
    end

    always @(negedge clk) begin
        if (checking && !rst) begin
            vectors++;
            if ({busy, done, result} !== {m_left != 0, m_left == 1, m_res}) begin
                miscompares++;
                $display("FAIL cycle_check t=%0t busy/done/result got %b/%b/%h want %b/%b/%h",
                         $time, busy, done, result, m_left != 0, m_left == 1, m_res);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Issue one op from an idle DUT and check result, done latency and busy duration
    task automatic run_lit(input string name, input logic [4:0] sel, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] want, input int lat_want);
        int lat = 0;
        int busy_cyc = 0;
        start = 1; ALUsel = sel; a = x; b = y;
        @(posedge clk); #1 start = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) begin lat = i; break; end
        end
        check({name, "_lat"}, lat, lat_want);
        check({name, "_busy"}, busy_cyc, lat_want);
        check(name, result, want);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int kill_at;
        rst = 1; start = 0; kill = 0; ALUsel = 0; a = 0; b = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        @(posedge clk); #1 checking = 1;

        run_lit("mul",     5'b10000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_lit("mulhu",   5'b10011, 32'd7, 32'hFFFFFFFD, 32'h00000006, 33);
        run_lit("mulh",    5'b10001, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        run_lit("mulhsu",  5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_lit("mulh_min",5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_lit("div",     5'b10100, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 33);
        run_lit("rem",     5'b10110, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 33);
        run_lit("divu",    5'b10101, 32'd20, 32'd3, 32'd6, 33);
        run_lit("remu",    5'b10111, 32'd20, 32'd3, 32'd2, 33);
        run_lit("div_ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_lit("rem_ovf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
        run_lit("divu_z",  5'b10101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        run_lit("rem_z",   5'b10110, 32'd5, 32'd0, 32'd5, 1);

        // Kill during CALC cycle 10
        start = 1; ALUsel = 5'b10000; a = 3; b = 5;
        @(posedge clk); #1 start = 0;
        repeat (9) begin @(posedge clk); #1; end
        kill = 1;
        @(posedge clk); #1 kill = 0;
        check("kill_busy", busy, 0);
        check("kill_result", result, 5);
        repeat (3) begin @(negedge clk); check("kill_no_done", done, 0); end
        @(posedge clk); #1;

        // start held high while busy must not disturb the running divide
        start = 1; ALUsel = 5'b10101; a = 100; b = 7;
        @(posedge clk); #1 ALUsel = 5'b10000; a = 9; b = 9;
        repeat (20) begin @(posedge clk); #1; end
        start = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        check("ignore_start_done", seen, 1);
        check("ignore_start_result", result, 14);
        @(posedge clk); #1;

        // Asynchronous reset mid-CALC
        start = 1; ALUsel = 5'b10100; a = 1000; b = 3;
        @(posedge clk); #1 start = 0;
        repeat (5) @(posedge clk);
        #3 rst = 1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        @(posedge clk); #1 rst = 0;

        start = 1; ALUsel = 5'b00000; a = 1; b = 1;
        repeat (3) begin @(posedge clk); #1; check("non_m_busy", busy, 0); end
        start = 0;

        // Random ops with junk starts while busy and occasional kills
        repeat (250) begin
            ALUsel = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 15))
                                                  : {2'b10, 3'($urandom_range(0, 7))};
            a = pick(); b = pick();
            start = 1;
            @(posedge clk); #1 start = 0;
            kill_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 34) : 0;
            for (int c = 1; c <= 40 && m_left != 0; c++) begin
                if (m_left > 2 && $urandom_range(0, 3) == 0) begin
                    start = 1; ALUsel = 5'($urandom_range(16, 23)); a = $urandom; b = $urandom;
                end else begin
                    start = 0;
                end
                kill = (c == kill_at);
                @(posedge clk); #1;
            end
            start = 0; kill = 0;
            if (m_left != 0) begin
                vectors++;
                miscompares++;
                $display("FAIL random_timeout left %0d want 0", m_left);
            end
        end

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
